// File: rtl/mem_proto_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_proto_pkg
//  Description : Shared encodings for the three-channel memory beat protocol
//                (per-channel transmit states and request channel codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_proto_pkg;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LO   = 2'd1,
    TX_HI   = 2'd2,
    TX_GAP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    CH_SDRAM = 2'd0,
    CH_FLASH = 2'd1,
    CH_ROM   = 2'd2,
    CH_BAD   = 2'd3
  } chan_t;

endpackage
`default_nettype wire

// File: rtl/mem_tx_chan.sv
`default_nettype none
// ============================================================================
//  Module      : mem_tx_chan
//  Description : One transmit channel: IDLE->LO->HI->GAP FSM, payload latch
//                and LO-phase wait counter with timeout abort. SPLIT=1 sends
//                the low half then the high half; SPLIT=0 repeats the payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_tx_chan
  import mem_proto_pkg::*;
#(
  parameter int BEAT_W  = 2,
  parameter int SPLIT   = 1,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [(SPLIT ? 2*BEAT_W : BEAT_W)-1:0] payload,
  input  logic                                    ready,
  output logic                                    valid,
  output logic [BEAT_W-1:0]                       data_o,
  output logic                                    done,
  output logic                                    err,
  output logic                                    idle,
  output logic [1:0]                              state
);

  localparam int              c_PAY_W = SPLIT ? 2*BEAT_W : BEAT_W;
  localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(TIMEOUT - 1);

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [c_PAY_W-1:0] r_payload;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               w_timeout;
  logic [BEAT_W-1:0]  w_beat0;
  logic [BEAT_W-1:0]  w_beat1;

  generate
    if (SPLIT != 0) begin : g_split
      assign w_beat0 = r_payload[BEAT_W-1:0];
      assign w_beat1 = r_payload[c_PAY_W-1:BEAT_W];
    end else begin : g_repeat
      assign w_beat0 = r_payload;
      assign w_beat1 = r_payload;
    end
  endgenerate

  // Abort fires on the last tolerated stalled cycle of the first beat.
  assign w_timeout = (r_state == TX_LO) && !ready && (r_cnt == c_LAST);

  // State, payload, wait counter and registered abort pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= TX_IDLE;
      r_payload <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_timeout;
      if ((r_state == TX_IDLE) && start) begin
        r_payload <= payload;
        r_cnt     <= '0;
      end else if ((r_state == TX_LO) && !ready && !w_timeout) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Next-state and output decode from registered state and payload only.
  always_comb begin
    w_state_nxt = r_state;
    valid       = 1'b0;
    data_o      = '0;
    done        = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (start) w_state_nxt = TX_LO;
      end
      TX_LO: begin
        valid  = 1'b1;
        data_o = w_beat0;
        if (ready)          w_state_nxt = TX_HI;
        else if (w_timeout) w_state_nxt = TX_IDLE;
      end
      TX_HI: begin
        valid  = 1'b1;
        data_o = w_beat1;
        if (ready) w_state_nxt = TX_GAP;
      end
      TX_GAP: begin
        done        = 1'b1;
        w_state_nxt = TX_IDLE;
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  assign err   = r_err;
  assign idle  = (r_state == TX_IDLE);
  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/mem_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_gen
//  Description : Request dispatcher driving the sdram, flash and rom beat
//                links concurrently, with error merge, state-tuple coverage
//                map and an all-channels-in-gap flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_gen
  import mem_proto_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       meta_reset,
  input  logic       req_valid,
  input  logic [1:0] req_chan,
  input  logic [3:0] req_data,
  output logic       req_ready,
  output logic       sdram_valid,
  output logic [1:0] sdram_data_o,
  input  logic       sdram_ready,
  output logic       flash_valid,
  output logic [3:0] flash_data_o,
  input  logic       flash_ready,
  output logic       rom_valid,
  output logic       rom_data_o,
  input  logic       rom_ready,
  output logic [2:0] tx_done,
  output logic       tx_err,
  output logic [5:0] coverage,
  output logic [5:0] io_cov_sum,
  output logic       bug
);

  logic [2:0]  w_idle;
  logic [2:0]  w_start;
  logic [2:0]  w_err;
  logic [1:0]  w_st_sdram;
  logic [1:0]  w_st_flash;
  logic [1:0]  w_st_rom;
  logic        w_accept;
  logic        r_bad_err;
  logic [5:0]  r_reg_state;
  logic [63:0] r_covmap;
  logic [5:0]  r_covsum;

  // Illegal channel is always accepted; legal ones only when their FSM idles.
  always_comb begin
    req_ready = 1'b1;
    case (req_chan)
      CH_SDRAM: req_ready = w_idle[0];
      CH_FLASH: req_ready = w_idle[1];
      CH_ROM:   req_ready = w_idle[2];
      default:  req_ready = 1'b1;
    endcase
  end

  assign w_accept   = req_valid && req_ready;
  assign w_start[0] = w_accept && (req_chan == CH_SDRAM);
  assign w_start[1] = w_accept && (req_chan == CH_FLASH);
  assign w_start[2] = w_accept && (req_chan == CH_ROM);

  mem_tx_chan #(.BEAT_W(2), .SPLIT(1), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_sdram (
    .clock(clock), .reset(reset), .start(w_start[0]), .payload(req_data),
    .ready(sdram_ready), .valid(sdram_valid), .data_o(sdram_data_o),
    .done(tx_done[0]), .err(w_err[0]), .idle(w_idle[0]), .state(w_st_sdram)
  );

  mem_tx_chan #(.BEAT_W(4), .SPLIT(0), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_flash (
    .clock(clock), .reset(reset), .start(w_start[1]), .payload(req_data),
    .ready(flash_ready), .valid(flash_valid), .data_o(flash_data_o),
    .done(tx_done[1]), .err(w_err[1]), .idle(w_idle[1]), .state(w_st_flash)
  );

  mem_tx_chan #(.BEAT_W(1), .SPLIT(1), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_rom (
    .clock(clock), .reset(reset), .start(w_start[2]), .payload(req_data[1:0]),
    .ready(rom_ready), .valid(rom_valid), .data_o(rom_data_o),
    .done(tx_done[2]), .err(w_err[2]), .idle(w_idle[2]), .state(w_st_rom)
  );

  // Illegal-channel request is dropped and reported one cycle later.
  always_ff @(posedge clock) begin
    if (reset) r_bad_err <= 1'b0;
    else       r_bad_err <= req_valid && (req_chan == CH_BAD);
  end

  assign tx_err = r_bad_err | (|w_err);

  // Coverage map survives protocol reset; only meta_reset clears it.
  always_ff @(posedge clock) begin
    r_reg_state <= {w_st_flash, w_st_sdram, w_st_rom};
    if (meta_reset) begin
      r_covmap <= '0;
      r_covsum <= '0;
    end else if (!r_covmap[r_reg_state]) begin
      r_covmap[r_reg_state] <= 1'b1;
      if (r_covsum != 6'd63) r_covsum <= r_covsum + 6'd1;
    end
  end

  assign coverage   = r_covsum;
  assign io_cov_sum = r_covsum;
  assign bug        = (w_st_sdram == TX_GAP) && (w_st_flash == TX_GAP) &&
                      (w_st_rom == TX_GAP);

endmodule
`default_nettype wire

// File: tb/tb_mem_req_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_gen
//  Description : Directed self-checking bench for mem_req_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_gen;

  localparam int c_TIMEOUT = 15;

  logic       clock = 1'b0;
  logic       reset, meta_reset, req_valid;
  logic [1:0] req_chan;
  logic [3:0] req_data;
  logic       req_ready;
  logic       sdram_valid, sdram_ready;
  logic [1:0] sdram_data_o;
  logic       flash_valid, flash_ready;
  logic [3:0] flash_data_o;
  logic       rom_valid, rom_data_o, rom_ready;
  logic [2:0] tx_done;
  logic       tx_err, bug;
  logic [5:0] coverage, io_cov_sum;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mem_req_gen #(.TIMEOUT(c_TIMEOUT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .meta_reset(meta_reset),
    .req_valid(req_valid), .req_chan(req_chan), .req_data(req_data),
    .req_ready(req_ready),
    .sdram_valid(sdram_valid), .sdram_data_o(sdram_data_o), .sdram_ready(sdram_ready),
    .flash_valid(flash_valid), .flash_data_o(flash_data_o), .flash_ready(flash_ready),
    .rom_valid(rom_valid), .rom_data_o(rom_data_o), .rom_ready(rom_ready),
    .tx_done(tx_done), .tx_err(tx_err), .coverage(coverage),
    .io_cov_sum(io_cov_sum), .bug(bug)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    repeat (3) step();
    outs = {sdram_valid, sdram_data_o, flash_valid, flash_data_o, rom_valid,
            rom_data_o, tx_done, tx_err, bug};
    n_cmp++; if (outs !== 15'd0) begin n_bad++; $display("FAIL reset_outs got=%h exp=0", outs); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_cmp++; if (coverage !== 6'd0 || io_cov_sum !== 6'd0) begin
      n_bad++; $display("FAIL reset_cov got=%0d/%0d exp=0", coverage, io_cov_sum); end
    reset = 1'b0; meta_reset = 1'b0;
    step();
    n_cmp++; if (coverage !== 6'd1) begin n_bad++; $display("FAIL cov_first got=%0d exp=1", coverage); end
  endtask

  task automatic test_sdram();
    sdram_ready = 1'b1;
    req_valid = 1'b1; req_chan = 2'd0; req_data = 4'hB;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL sdram_ready_idle got=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    #1;
    n_cmp++; if ({sdram_valid, sdram_data_o} !== 3'b111) begin
      n_bad++; $display("FAIL sdram_beat0 got=%b exp=111", {sdram_valid, sdram_data_o}); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL sdram_busy_ready got=%b exp=0", req_ready); end
    step();
    n_cmp++; if ({sdram_valid, sdram_data_o} !== 3'b110) begin
      n_bad++; $display("FAIL sdram_beat1 got=%b exp=110", {sdram_valid, sdram_data_o}); end
    step();
    n_cmp++; if ({sdram_valid, sdram_data_o, tx_done} !== 6'b000_001) begin
      n_bad++; $display("FAIL sdram_gap got=%b exp=000001", {sdram_valid, sdram_data_o, tx_done}); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL sdram_gap_ready got=%b exp=0", req_ready); end
    step();
    n_cmp++; if (tx_done !== 3'b000 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL sdram_idle got done=%b ready=%b exp 000/1", tx_done, req_ready); end
    step();
    n_cmp++; if (coverage !== 6'd4 || io_cov_sum !== 6'd4) begin
      n_bad++; $display("FAIL sdram_cov got=%0d/%0d exp=4", coverage, io_cov_sum); end
  endtask

  task automatic test_flash();
    flash_ready = 1'b0;
    req_valid = 1'b1; req_chan = 2'd1; req_data = 4'h6;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({flash_valid, flash_data_o} !== 5'b1_0110) begin
        n_bad++; $display("FAIL flash_lo_stall%0d got=%b exp=10110", i, {flash_valid, flash_data_o}); end
      step();
    end
    flash_ready = 1'b1;
    #1;
    n_cmp++; if ({flash_valid, flash_data_o} !== 5'b1_0110) begin
      n_bad++; $display("FAIL flash_lo got=%b exp=10110", {flash_valid, flash_data_o}); end
    step();
    flash_ready = 1'b0;
    n_cmp++; if ({flash_valid, flash_data_o} !== 5'b1_0110) begin
      n_bad++; $display("FAIL flash_hi got=%b exp=10110", {flash_valid, flash_data_o}); end
    step();
    flash_ready = 1'b1;
    n_cmp++; if ({flash_valid, flash_data_o, tx_done} !== 8'b1_0110_000) begin
      n_bad++; $display("FAIL flash_hi_stall got=%b exp=10110000", {flash_valid, flash_data_o, tx_done}); end
    step();
    n_cmp++; if ({flash_valid, flash_data_o, tx_done} !== 8'b0_0000_010) begin
      n_bad++; $display("FAIL flash_gap got=%b exp=00000010", {flash_valid, flash_data_o, tx_done}); end
    step();
  endtask

  task automatic test_rom_timeout();
    rom_ready = 1'b0;
    req_valid = 1'b1; req_chan = 2'd2; req_data = 4'h2;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < c_TIMEOUT; i++) begin
      n_cmp++; if ({rom_valid, rom_data_o, tx_err} !== 3'b100) begin
        n_bad++; $display("FAIL rom_wait%0d got=%b exp=100", i, {rom_valid, rom_data_o, tx_err}); end
      step();
    end
    n_cmp++; if ({rom_valid, rom_data_o, tx_err} !== 3'b001) begin
      n_bad++; $display("FAIL rom_abort got=%b exp=001", {rom_valid, rom_data_o, tx_err}); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rom_abort_idle got=%b exp=1", req_ready); end
    step();
    n_cmp++; if (tx_err !== 1'b0) begin n_bad++; $display("FAIL rom_err_pulse got=%b exp=0", tx_err); end
    rom_ready = 1'b1;
  endtask

  task automatic test_illegal();
    req_valid = 1'b1; req_chan = 2'd3; req_data = 4'hF;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bad_ready got=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    n_cmp++; if ({tx_err, sdram_valid, flash_valid, rom_valid} !== 4'b1000) begin
      n_bad++; $display("FAIL bad_err got=%b exp=1000", {tx_err, sdram_valid, flash_valid, rom_valid}); end
    step();
    n_cmp++; if ({tx_err, sdram_valid, flash_valid, rom_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL bad_after got=%b exp=0000", {tx_err, sdram_valid, flash_valid, rom_valid}); end
  endtask

  task automatic test_bug();
    sdram_ready = 1'b0; flash_ready = 1'b0; rom_ready = 1'b0;
    req_valid = 1'b1; req_data = 4'h5;
    for (int c = 0; c < 3; c++) begin
      req_chan = 2'(c);
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bug_accept%0d got=%b exp=1", c, req_ready); end
      step();
    end
    req_valid = 1'b0;
    sdram_ready = 1'b1; flash_ready = 1'b1; rom_ready = 1'b1;
    n_cmp++; if ({sdram_valid, flash_valid, rom_valid, bug} !== 4'b1110) begin
      n_bad++; $display("FAIL bug_lo got=%b exp=1110", {sdram_valid, flash_valid, rom_valid, bug}); end
    step();
    n_cmp++; if (bug !== 1'b0) begin n_bad++; $display("FAIL bug_hi got=%b exp=0", bug); end
    step();
    n_cmp++; if ({bug, tx_done} !== 4'b1111) begin
      n_bad++; $display("FAIL bug_gap got=%b exp=1111", {bug, tx_done}); end
    step();
    n_cmp++; if ({bug, tx_done} !== 4'b0000) begin
      n_bad++; $display("FAIL bug_clear got=%b exp=0000", {bug, tx_done}); end
  endtask

  task automatic test_reset_mid();
    logic [14:0] outs;
    sdram_ready = 1'b1;
    req_valid = 1'b1; req_chan = 2'd0; req_data = 4'h9;
    step();
    req_valid = 1'b0;
    step();
    n_cmp++; if ({sdram_valid, sdram_data_o} !== 3'b110) begin
      n_bad++; $display("FAIL rst_hi got=%b exp=110", {sdram_valid, sdram_data_o}); end
    reset = 1'b1;
    step();
    outs = {sdram_valid, sdram_data_o, flash_valid, flash_data_o, rom_valid,
            rom_data_o, tx_done, tx_err, bug};
    n_cmp++; if (outs !== 15'd0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid got=%h ready=%b exp 0/1", outs, req_ready); end
    reset = 1'b0;
    step();
    n_cmp++; if ({sdram_valid, tx_done, tx_err} !== 5'b0) begin
      n_bad++; $display("FAIL rst_after got=%b exp=00000", {sdram_valid, tx_done, tx_err}); end
  endtask

  task automatic test_meta_reset();
    meta_reset = 1'b1;
    step();
    n_cmp++; if (coverage !== 6'd0 || io_cov_sum !== 6'd0) begin
      n_bad++; $display("FAIL meta_clear got=%0d/%0d exp=0", coverage, io_cov_sum); end
    meta_reset = 1'b0;
    step();
    n_cmp++; if (coverage !== 6'd1) begin n_bad++; $display("FAIL meta_recount got=%0d exp=1", coverage); end
    step();
    n_cmp++; if (io_cov_sum !== 6'd1) begin n_bad++; $display("FAIL meta_hold got=%0d exp=1", io_cov_sum); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; meta_reset = 1'b1;
    req_valid = 1'b0; req_chan = 2'd0; req_data = 4'h0;
    sdram_ready = 1'b1; flash_ready = 1'b1; rom_ready = 1'b1;
    test_reset();
    test_sdram();
    test_flash();
    test_rom_timeout();
    test_illegal();
    test_bug();
    test_reset_mid();
    test_meta_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
